refresh_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display. It divides the system clock into a digit-refresh tick and generates the 2-bit `refreshcounter` that drives the anode stage. It also presents the matching 4-bit digit code and a blank flag to the segment decoder. Display updates are double-buffered and take effect only at a frame boundary, so the display never shows a torn value.

---
 rtl/disp_pkg.sv | 35 +++
 rtl/tick_gen.sv | 31 +++
 rtl/refresh_scan_ctrl.sv | 96 +++++++++
 tb/tb_refresh_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, types and digit helpers for the four-digit display path.
package disp_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int IDX_W       = 2;
    localparam int NIB_W       = 4;
    localparam int VAL_W       = 16;
    localparam int CLK_DIV_DEF = 100_000;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [NIB_W-1:0] nib_t;
    typedef logic [VAL_W-1:0] val_t;

    // Nibble of a display value at the given digit index.
    function automatic nib_t nib_sel(input val_t val, input idx_t idx);
        return val[{idx, 2'b00} +: NIB_W];
    endfunction

    // Leading-zero suppression: a nonzero index is blanked when it and
    // every more-significant nibble are zero. Digit 0 always shows.
    function automatic logic lz_blank(input val_t val, input idx_t idx, input logic en);
        logic b;
        b = 1'b0;
        if (en && (idx != '0)) begin
            b = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i >= int'(idx)) && (val[i*NIB_W +: NIB_W] != '0)) begin
                    b = 1'b0;
                end
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Digit-slot prescaler: one-cycle tick every CLK_DIV system clocks.
module tick_gen
    import disp_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // With CLK_DIV = 1 the counter sits at 0 and tick is permanently high.
    assign tick = (div_cnt == LAST);

    // Free-running 0..CLK_DIV-1 counter, restarted on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/refresh_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous,
// double-buffered display updates and optional leading-zero blanking.
module refresh_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] value_in,
    input  logic             load,
    output logic             load_ack,
    output logic [IDX_W-1:0] refreshcounter,
    output logic [NIB_W-1:0] digit,
    output logic             blank,
    output logic             frame_tick
);

    logic tick;
    logic wrap;
    logic commit;
    idx_t idx_nxt;
    val_t active;
    val_t active_nxt;
    val_t pending;
    logic pend_v;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Next index, frame wrap, and the value that will be shown after this edge.
    // A load coinciding with the wrap bypasses the pending buffer.
    always_comb begin
        idx_nxt    = refreshcounter;
        wrap       = 1'b0;
        commit     = 1'b0;
        active_nxt = active;
        if (tick) begin
            idx_nxt = refreshcounter + 1'b1;
            wrap    = (refreshcounter == idx_t'(NUM_DIGITS - 1));
        end
        if (wrap) begin
            if (load) begin
                active_nxt = value_in;
                commit     = 1'b1;
            end else if (pend_v) begin
                active_nxt = pending;
                commit     = 1'b1;
            end
        end
    end

    // Load buffer: latest load wins; cleared by every frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            pend_v  <= 1'b0;
        end else begin
            if (load) begin
                pending <= value_in;
            end
            if (wrap) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pend_v <= 1'b1;
            end
        end
    end

    // Displayed value, index and decoder outputs all move on the same edge
    // so digit/blank always describe the index being shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active         <= '0;
            refreshcounter <= '0;
            digit          <= '0;
            blank          <= 1'b0;
            frame_tick     <= 1'b0;
            load_ack       <= 1'b0;
        end else begin
            active         <= active_nxt;
            refreshcounter <= idx_nxt;
            digit          <= nib_sel(active_nxt, idx_nxt);
            blank          <= lz_blank(active_nxt, idx_nxt, BLANK_LZ);
            frame_tick     <= wrap;
            load_ack       <= commit;
        end
    end

endmodule

// File: tb/tb_refresh_scan_ctrl.sv
// Randomized bench for refresh_scan_ctrl: three instances (CLK_DIV=4 with
// and without blanking, CLK_DIV=1) checked against a frame-level model.
module tb_refresh_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;

    logic [1:0] rc   [3];
    logic [3:0] dg   [3];
    logic       bl   [3];
    logic       ft   [3];
    logic       ack  [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    refresh_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .load_ack(ack[0]), .refreshcounter(rc[0]), .digit(dg[0]),
        .blank(bl[0]), .frame_tick(ft[0]));

    refresh_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .load_ack(ack[1]), .refreshcounter(rc[1]), .digit(dg[1]),
        .blank(bl[1]), .frame_tick(ft[1]));

    refresh_scan_ctrl #(.CLK_DIV(1), .BLANK_LZ(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .load_ack(ack[2]), .refreshcounter(rc[2]), .digit(dg[2]),
        .blank(bl[2]), .frame_tick(ft[2]));

    // Reference model: time since reset release determines index and frame
    // boundaries; the shown value changes only at frame boundaries.
    int          cdv    [3] = '{4, 4, 1};
    bit          blz    [3] = '{1'b1, 1'b0, 1'b1};
    int          edges  [3];
    logic [15:0] shown  [3];
    logic [15:0] pendval[3];
    bit          pend   [3];
    bit          eack   [3];
    bit          eft    [3];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            edges[k] = 0; shown[k] = '0; pendval[k] = '0;
            pend[k] = 1'b0; eack[k] = 1'b0; eft[k] = 1'b0;
        end
    endtask

    function automatic int m_idx(input int k);
        return (edges[k] / cdv[k]) % 4;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit slot_end;
                bit wrap;
                slot_end = ((edges[k] % cdv[k]) == cdv[k] - 1);
                wrap     = slot_end && (m_idx(k) == 3);
                if (load) begin
                    pendval[k] = value_in;
                    pend[k]    = 1'b1;
                end
                eack[k] = 1'b0;
                eft[k]  = wrap;
                if (wrap && pend[k]) begin
                    shown[k] = pendval[k];
                    pend[k]  = 1'b0;
                    eack[k]  = 1'b1;
                end
                edges[k]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            int          i;
            logic [15:0] upper;
            i     = m_idx(k);
            upper = shown[k] >> (4 * i);
            check($sformatf("%s.idx[%0d]", tag, k), {14'd0, rc[k]}, 16'(i));
            check($sformatf("%s.digit[%0d]", tag, k), {12'd0, dg[k]}, {12'd0, upper[3:0]});
            check($sformatf("%s.blank[%0d]", tag, k), {15'd0, bl[k]},
                  {15'd0, (blz[k] && i > 0 && upper == 16'd0)});
            check($sformatf("%s.frame_tick[%0d]", tag, k), {15'd0, ft[k]}, {15'd0, eft[k]});
            check($sformatf("%s.load_ack[%0d]", tag, k), {15'd0, ack[k]}, {15'd0, eack[k]});
        end
    endtask

    // One clock: drive inputs away from the edge, then update model and compare.
    task automatic cycle(input bit ld, input logic [15:0] v, input string tag);
        load     = ld;
        value_in = v;
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int j = 0; j < n; j++) cycle(1'b0, 16'h0000, tag);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        model_reset();
        check_all("rst_now");
        run(2, "rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        model_reset();
        #1;
        check_all("reset");
        run(2, "reset_hold");
        rst_n = 1'b1;

        cycle(1'b1, 16'h1234, "ld1234");
        run(40, "scan1234");

        cycle(1'b1, 16'h0050, "ld0050");
        run(36, "lz0050");
        cycle(1'b1, 16'h0000, "ld0000");
        run(36, "lz0000");

        for (int g = 0; g < 64 && m_idx(0) != 1; g++) cycle(1'b0, 16'h0, "seek1");
        cycle(1'b1, 16'hABCD, "ldABCD");
        run(24, "abcd");

        for (int g = 0; g < 64 && !(m_idx(0) == 0 && (edges[0] % 4) == 1); g++)
            cycle(1'b0, 16'h0, "seek0");
        cycle(1'b1, 16'h1111, "ld1111");
        run(3, "b2b");
        cycle(1'b1, 16'h2222, "ld2222");
        run(24, "b2b");

        for (int g = 0; g < 64 && !((edges[0] % 4) == 3 && m_idx(0) == 3); g++)
            cycle(1'b0, 16'h0, "seekwrap");
        cycle(1'b1, 16'h0F00, "ldwrap");
        run(20, "wrapld");

        for (int g = 0; g < 64 && m_idx(0) != 2; g++) cycle(1'b0, 16'h0, "seek2");
        cycle(1'b1, 16'h5A5A, "ldpend");
        do_reset();
        run(40, "postrst");

        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                logic [31:0] r;
                r = 32'($urandom) & 32'h0000_FFFF;
                r = r >> (4 * $urandom_range(0, 4));
                cycle($urandom_range(0, 7) == 0, r[15:0], "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
